// File: rtl/fp_class_unit.sv
// Streaming IEEE-754 classifier: one-hot RISC-V fclass vector through a one-entry
// valid/ready output register, with saturating per-class and total counters.
module fp_class_unit #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   in_num,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [9:0]             out_type,
    input  logic                   out_ready,
    input  logic                   clr,
    input  logic [3:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_data
);

    localparam int unsigned NUM_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned NUM_CLS = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               sgn;
    logic [EXP_W-1:0]   expo;
    logic [MAN_W-1:0]   man;
    logic [9:0]         cls;
    logic               accept;
    logic [CNT_W-1:0]   cnt [NUM_CLS];
    logic [CNT_W-1:0]   tot;

    assign sgn  = in_num[NUM_W-1];
    assign expo = in_num[NUM_W-2 -: EXP_W];
    assign man  = in_num[MAN_W-1:0];

    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode fields into exactly one class bit; NaN quietness comes from the mantissa MSB.
    always_comb begin
        cls = '0;
        if (&expo) begin
            if (~|man)              cls[sgn ? 0 : 7] = 1'b1;
            else if (man[MAN_W-1])  cls[9] = 1'b1;
            else                    cls[8] = 1'b1;
        end else if (~|expo) begin
            if (~|man)              cls[sgn ? 3 : 4] = 1'b1;
            else                    cls[sgn ? 2 : 5] = 1'b1;
        end else begin
            cls[sgn ? 1 : 6] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_type  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_type  <= cls;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_type  <= '0;
        end
    end

    // clr wins over the old value but a coincident accept still counts afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLS; i++) cnt[i] <= '0;
            tot <= '0;
        end else begin
            for (int i = 0; i < NUM_CLS; i++) begin
                if (clr)
                    cnt[i] <= CNT_W'(accept && cls[i]);
                else if (accept && cls[i] && (cnt[i] != CNT_MAX))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
            if (clr)
                tot <= CNT_W'(accept);
            else if (accept && (tot != CNT_MAX))
                tot <= tot + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < NUM_CLS; i++) begin
            if (cnt_sel == 4'(i)) cnt_data = cnt[i];
        end
        if (cnt_sel == 4'd10) cnt_data = tot;
    end

endmodule

// File: tb/tb_fp_class_unit.sv
// Directed bench for fp_class_unit: single precision, 4-bit counters and half precision.
module tb_fp_class_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters
    logic        a_valid, a_iready, a_ovalid, a_oready, a_clr;
    logic [31:0] a_num;
    logic [9:0]  a_type;
    logic [3:0]  a_sel;
    logic [15:0] a_cnt;

    // Instance B: 4-bit counters
    logic        b_valid, b_iready, b_ovalid, b_oready, b_clr;
    logic [31:0] b_num;
    logic [9:0]  b_type;
    logic [3:0]  b_sel;
    logic [3:0]  b_cnt;

    // Instance C: half precision
    logic        c_valid, c_iready, c_ovalid, c_oready, c_clr;
    logic [15:0] c_num;
    logic [9:0]  c_type;
    logic [3:0]  c_sel;
    logic [15:0] c_cnt;

    fp_class_unit u_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_num(a_num), .in_ready(a_iready),
        .out_valid(a_ovalid), .out_type(a_type), .out_ready(a_oready), .clr(a_clr),
        .cnt_sel(a_sel), .cnt_data(a_cnt)
    );

    fp_class_unit #(.EXP_W(8), .MAN_W(23), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_num(b_num), .in_ready(b_iready),
        .out_valid(b_ovalid), .out_type(b_type), .out_ready(b_oready), .clr(b_clr),
        .cnt_sel(b_sel), .cnt_data(b_cnt)
    );

    fp_class_unit #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_valid), .in_num(c_num), .in_ready(c_iready),
        .out_valid(c_ovalid), .out_type(c_type), .out_ready(c_oready), .clr(c_clr),
        .cnt_sel(c_sel), .cnt_data(c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 1'b1; a_num = 32'h3F80_0000; a_oready = 1'b1; a_clr = 1'b0; a_sel = 4'd10;
        b_valid = 1'b0; b_num = '0; b_oready = 1'b1; b_clr = 1'b0; b_sel = 4'd0;
        c_valid = 1'b0; c_num = '0; c_oready = 1'b1; c_clr = 1'b0; c_sel = 4'd0;
        repeat (3) tick();
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_ovalid); end
        total++; if (a_type !== 10'h000) begin bad++; $display("FAIL reset_type got=%h exp=000", a_type); end
        total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", a_iready); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL reset_tot got=%0d exp=0", a_cnt); end
        reset = 1'b0;
        a_valid = 1'b0;
        #1;
        total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", a_iready); end
    endtask

    task automatic test_class_sweep();
        logic [31:0] vec [10];
        logic [9:0]  exp_t [10];
        vec = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000,
                32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0001, 32'hFFC0_0000, 32'h807F_FFFF};
        exp_t = '{10'h010, 10'h008, 10'h020, 10'h040, 10'h002,
                  10'h080, 10'h001, 10'h100, 10'h200, 10'h004};
        a_oready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1;
            a_num = vec[i];
            tick();
            total++;
            if (a_ovalid !== 1'b1 || a_type !== exp_t[i]) begin
                bad++;
                $display("FAIL sweep[%0d] num=%h got valid=%b type=%h exp valid=1 type=%h",
                         i, vec[i], a_ovalid, a_type, exp_t[i]);
            end
        end
        a_valid = 1'b0;
        for (int s = 0; s <= 10; s++) begin
            a_sel = 4'(s);
            #1;
            total++;
            if (a_cnt !== ((s == 10) ? 16'd10 : 16'd1)) begin
                bad++;
                $display("FAIL sweep_cnt sel=%0d got=%0d exp=%0d", s, a_cnt, (s == 10) ? 10 : 1);
            end
        end
        tick();
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL sweep_drain got=%b exp=0", a_ovalid); end
    endtask

    task automatic test_backpressure();
        a_clr = 1'b1; a_valid = 1'b0;
        tick();
        a_clr = 1'b0;
        a_valid = 1'b1; a_num = 32'h3F80_0000; a_oready = 1'b0;
        tick();
        a_num = 32'h7F80_0000;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (a_iready !== 1'b0 || a_ovalid !== 1'b1 || a_type !== 10'h040) begin
                bad++;
                $display("FAIL bp_hold[%0d] got ready=%b valid=%b type=%h exp ready=0 valid=1 type=040",
                         i, a_iready, a_ovalid, a_type);
            end
            tick();
        end
        a_oready = 1'b1;
        #1;
        total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", a_iready); end
        tick();
        a_valid = 1'b0;
        total++;
        if (a_ovalid !== 1'b1 || a_type !== 10'h080) begin
            bad++;
            $display("FAIL bp_next got valid=%b type=%h exp valid=1 type=080", a_ovalid, a_type);
        end
        a_sel = 4'd6; #1;
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL bp_cnt6 got=%0d exp=1", a_cnt); end
        a_sel = 4'd7; #1;
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL bp_cnt7 got=%0d exp=1", a_cnt); end
        a_sel = 4'd10; #1;
        total++; if (a_cnt !== 16'd2) begin bad++; $display("FAIL bp_tot got=%0d exp=2", a_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        b_oready = 1'b1; b_valid = 1'b1; b_num = 32'h0000_0000;
        repeat (17) tick();
        b_valid = 1'b0;
        b_sel = 4'd4; #1;
        total++; if (b_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", b_cnt); end
        b_sel = 4'd10; #1;
        total++; if (b_cnt !== 4'd15) begin bad++; $display("FAIL sat_tot got=%0d exp=15", b_cnt); end
        b_valid = 1'b1; b_num = 32'h8000_0000;
        tick();
        b_valid = 1'b0;
        total++; if (b_type !== 10'h008) begin bad++; $display("FAIL sat_negzero_type got=%h exp=008", b_type); end
        b_sel = 4'd3; #1;
        total++; if (b_cnt !== 4'd1) begin bad++; $display("FAIL sat_cnt3 got=%0d exp=1", b_cnt); end
        b_sel = 4'd10; #1;
        total++; if (b_cnt !== 4'd15) begin bad++; $display("FAIL sat_tot_hold got=%0d exp=15", b_cnt); end
        b_sel = 4'd4; #1;
        total++; if (b_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt4_hold got=%0d exp=15", b_cnt); end
    endtask

    task automatic test_clr_collision();
        a_oready = 1'b1; a_valid = 1'b1; a_num = 32'h4000_0000;
        repeat (5) tick();
        a_sel = 4'd6; #1;
        total++; if (a_cnt !== 16'd6) begin bad++; $display("FAIL clr_pre_cnt6 got=%0d exp=6", a_cnt); end
        a_num = 32'h7FC0_0000; a_clr = 1'b1;
        tick();
        a_clr = 1'b0; a_valid = 1'b0;
        total++; if (a_type !== 10'h200) begin bad++; $display("FAIL clr_type got=%h exp=200", a_type); end
        a_sel = 4'd9; #1;
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL clr_cnt9 got=%0d exp=1", a_cnt); end
        a_sel = 4'd6; #1;
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt6 got=%0d exp=0", a_cnt); end
        a_sel = 4'd10; #1;
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL clr_tot got=%0d exp=1", a_cnt); end
        a_sel = 4'd12; #1;
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL clr_sel12 got=%0d exp=0", a_cnt); end
        tick();
    endtask

    task automatic test_reset_midstream();
        a_oready = 1'b0; a_valid = 1'b1; a_num = 32'hBF80_0000;
        tick();
        total++; if (a_ovalid !== 1'b1 || a_type !== 10'h002) begin
            bad++; $display("FAIL rst_mid_held got valid=%b type=%h exp valid=1 type=002", a_ovalid, a_type);
        end
        a_num = 32'h7F80_0000;
        reset = 1'b1;
        tick();
        total++; if (a_ovalid !== 1'b0 || a_type !== 10'h000) begin
            bad++; $display("FAIL rst_mid_out got valid=%b type=%h exp valid=0 type=000", a_ovalid, a_type);
        end
        total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1'b0", a_iready); end
        reset = 1'b0;
        a_valid = 1'b0;
        #1;
        total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after got=%b exp=1", a_iready); end
        for (int s = 0; s <= 10; s++) begin
            a_sel = 4'(s);
            #1;
            total++;
            if (a_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt sel=%0d got=%0d exp=0", s, a_cnt); end
        end
        a_oready = 1'b1;
        tick();
        total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL rst_mid_dropped got=%b exp=0", a_ovalid); end
    endtask

    task automatic test_half_precision();
        logic [15:0] vec [5];
        logic [9:0]  exp_t [5];
        vec   = '{16'h7E00, 16'h7C01, 16'hFC00, 16'h0200, 16'h3C00};
        exp_t = '{10'h200, 10'h100, 10'h001, 10'h020, 10'h040};
        c_oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_valid = 1'b1;
            c_num = vec[i];
            tick();
            total++;
            if (c_ovalid !== 1'b1 || c_type !== exp_t[i]) begin
                bad++;
                $display("FAIL half[%0d] num=%h got valid=%b type=%h exp valid=1 type=%h",
                         i, vec[i], c_ovalid, c_type, exp_t[i]);
            end
        end
        c_valid = 1'b0;
        c_sel = 4'd10; #1;
        total++; if (c_cnt !== 16'd5) begin bad++; $display("FAIL half_tot got=%0d exp=5", c_cnt); end
    endtask

    initial begin
        test_reset();
        test_class_sweep();
        test_backpressure();
        test_saturation();
        test_clr_collision();
        test_reset_midstream();
        test_half_precision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_class_unit.md
# fp_class_unit

Streaming, parametrised IEEE-754 classifier. Each accepted operand is decoded into a 10-bit one-hot class vector in RISC-V fclass order, separating sign, signalling NaN and quiet NaN. The vector is presented through a one-entry valid/ready output register. Saturating per-class and total counters feed statistics readout. The unit sits between an operand source (register file or load path) and any consumer of class flags.

## Interface
- EXP_W, 8, exponent field width (≥2)
- MAN_W, 23, mantissa field width (≥2)
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand present
- in_num  in  1+EXP_W+MAN_W  operand as {sign, exponent, mantissa}
- in_ready  out  1  unit can accept an operand this cycle
- out_valid  out  1  out_type holds a result
- out_type  out  10  one-hot class of the held result
- out_ready  in  1  consumer takes the result this cycle
- clr  in  1  synchronous clear of all counters
- cnt_sel  in  4  counter select: 0–9 per-class, 10 total
- cnt_data  out  CNT_W  selected counter value

## Operation
- Field split: s = MSB, e = next EXP_W bits, m = low MAN_W bits. "e all-ones" means e == {EXP_W{1'b1}}.
- Class bit set in out_type:
  - bit0: −inf (s=1, e all-ones, m=0)
  - bit1: −normal (s=1, e≠0, e not all-ones)
  - bit2: −subnormal (s=1, e=0, m≠0)
  - bit3: −zero (s=1, e=0, m=0)
  - bits 4–7: +zero, +subnormal, +normal, +inf, same rules with s=0
  - bit8: sNaN (e all-ones, m≠0, m[MAN_W-1]=0), either sign
  - bit9: qNaN (e all-ones, m[MAN_W-1]=1), either sign
- Exactly one bit of out_type is set whenever out_valid=1.
- Handshakes:
  - Accept: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
  - in_ready = !reset && (!out_valid || out_ready), giving full throughput when the consumer is always ready.
- Output register:
  - On accept: out_type ← class(in_num), out_valid ← 1.
  - On an output handshake with no accept: out_valid ← 0, out_type ← 0.
  - While out_valid=1 and out_ready=0: out_type and out_valid hold. in_num changes have no effect.
- Counters:
  - cnt[0..9] track the classes; tot counts all accepts.
  - On accept, cnt[class] and tot each increment by 1, saturating at 2^CNT_W−1. A saturated counter never wraps.
  - clr zeroes all counters. If clr coincides with an accept, the class counter and tot end at 1 (clear, then count).
- cnt_data is a combinational mux of the registered counters: cnt_sel 0–9 → cnt[sel], 10 → tot, 11–15 → 0.

## Timing
- Latency: operand accepted at edge N gives out_valid=1 with its class after edge N, visible in cycle N+1.
- Back-to-back: accept and output handshake in the same cycle replace the result, and out_valid stays 1.
- Counters reflect an accept from the cycle after the accepting edge. cnt_data has no extra register stage.
- Reset, sampled at any edge, including mid-stream with a result held:
  - out_valid=0, out_type=0, all counters 0, in_ready=0.
  - The pending result is dropped and is never presented.
  - An in_valid during reset is not accepted and not counted.
- First cycle after reset is deasserted: in_ready=1.

## Test plan
- Class sweep, default params, out_ready=1, one operand per cycle: 0x00000000→0x010, 0x80000000→0x008, 0x00000001→0x020, 0x3F800000→0x040, 0xBF800000→0x002, 0x7F800000→0x080, 0xFF800000→0x001, 0x7F800001→0x100, 0xFFC00000→0x200, 0x807FFFFF→0x004. Each result appears one cycle after its accept, and tot=10 afterward.
- Backpressure: accept 0x3F800000, hold out_ready=0 for 3 cycles while driving in_valid with 0x7F800000:
  - in_ready=0 and out_type=0x040 stable throughout.
  - The cycle out_ready=1, the new operand is accepted, and 0x080 follows next cycle.
  - cnt[6]=1, cnt[7]=1.
- Saturation, CNT_W=4: 17 accepts of +zero → cnt_sel=4 reads 15 and cnt_sel=10 reads 15. One further −zero → cnt[3]=1, tot stays 15.
- clr collision: after 5 +normal accepts, assert clr in the same cycle as a qNaN accept → cnt[9]=1, cnt[6]=0, tot=1. cnt_sel=12 reads 0.
- Reset mid-operation: hold a result with out_ready=0, then assert reset 1 cycle → out_valid=0, out_type=0, all counters 0. Next cycle in_ready=1.
- Parametrisation, EXP_W=5, MAN_W=10 (half precision): 0x7E00→0x200, 0x7C01→0x100, 0xFC00→0x001, 0x0200→0x020, 0x3C00→0x040.
